// File: rtl/timer_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one down-counting delay timer among NREQ requesters.
// Grant one edge after req is seen in IDLE, service lasts dly+1 cycles; no backpressure, cancel aborts.
module timer_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*N-1:0] dly_i,
    input  logic              cancel_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              busy_o,
    output logic [N-1:0]      remain_o,
    output logic [NREQ-1:0]   done_o,
    output logic [NREQ-1:0]   aborted_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, COUNT} state_t;

    state_t          state_q;
    logic [PW-1:0]   last_q;
    logic [NREQ-1:0] gnt_q;
    logic            busy_q;
    logic [N-1:0]    remain_q;
    logic [NREQ-1:0] done_q;
    logic [NREQ-1:0] aborted_q;

    logic            sel_vld;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   cand;

    // Scan from farthest to nearest so the candidate just after last_q is the final writer.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = PW'((int'(last_q) + k) % NREQ);
            if (req_i[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            last_q    <= PW'(NREQ - 1);
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            remain_q  <= '0;
            done_q    <= '0;
            aborted_q <= '0;
        end else begin
            done_q    <= '0;
            aborted_q <= '0;
            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        gnt_q    <= NREQ'(1) << sel_idx;
                        last_q   <= sel_idx;
                        remain_q <= dly_i[int'(sel_idx)*N +: N];
                        busy_q   <= 1'b1;
                        state_q  <= COUNT;
                    end
                end
                COUNT: begin
                    if (cancel_i) begin
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        aborted_q <= gnt_q;
                        remain_q  <= '0;
                        state_q   <= IDLE;
                    end else if (remain_q == '0) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= gnt_q;
                        state_q <= IDLE;
                    end else begin
                        remain_q <= remain_q - N'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = busy_q;
    assign remain_o  = remain_q;
    assign done_o    = done_q;
    assign aborted_o = aborted_q;
endmodule

// File: tb/tb_timer_arbiter.sv
`timescale 1ns/1ps
// Directed bench for timer_arbiter with a cycle-level reference model checked every falling edge.
module tb_timer_arbiter;
    localparam int N    = 8;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] dly;
    logic              cancel;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [N-1:0]      remain;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   aborted;

    int total = 0;
    int bad   = 0;

    timer_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .dly_i     (dly),
        .cancel_i  (cancel),
        .gnt_o     (gnt),
        .busy_o    (busy),
        .remain_o  (remain),
        .done_o    (done),
        .aborted_o (aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: who owns the timer, how many cycles remain, last pulses.
    bit m_srv;
    int m_own, m_left, m_last, m_done, m_ab, m_pick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_srv  <= 1'b0;
            m_own  <= 0;
            m_left <= 0;
            m_last <= NREQ - 1;
            m_done <= -1;
            m_ab   <= -1;
        end else begin
            m_done <= -1;
            m_ab   <= -1;
            if (!m_srv) begin
                m_pick = -1;
                for (int k = 1; k <= NREQ && m_pick < 0; k++)
                    if (req[(m_last + k) % NREQ]) m_pick = (m_last + k) % NREQ;
                if (m_pick >= 0) begin
                    m_srv  <= 1'b1;
                    m_own  <= m_pick;
                    m_last <= m_pick;
                    m_left <= int'(dly[m_pick*N +: N]);
                end
            end else if (cancel) begin
                m_ab   <= m_own;
                m_srv  <= 1'b0;
                m_left <= 0;
            end else if (m_left == 0) begin
                m_done <= m_own;
                m_srv  <= 1'b0;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    logic [NREQ-1:0] e_gnt, e_done, e_ab;
    always @(negedge clk) begin
        e_gnt  = '0;
        e_done = '0;
        e_ab   = '0;
        if (m_srv) e_gnt[m_own] = 1'b1;
        if (m_done >= 0) e_done[m_done] = 1'b1;
        if (m_ab >= 0) e_ab[m_ab] = 1'b1;
        chk("model_gnt", gnt, e_gnt);
        chk("model_busy", busy, m_srv);
        chk("model_remain", remain, m_left);
        chk("model_done", done, e_done);
        chk("model_aborted", aborted, e_ab);
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    // Single-requester service: grant length and done pulse.
    task automatic svc(input int idx, input int d, input string nm);
        int len = 0;
        int n = 0;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        dly[idx*N +: N] = N'(d);
        req = oh;
        tick();
        chk({nm, "_gnt"}, gnt, oh);
        req = '0;
        while (gnt !== '0 && n < 400) begin
            len++;
            tick();
            n++;
        end
        chk({nm, "_len"}, len, d + 1);
        chk({nm, "_done"}, done, oh);
    endtask

    logic [NREQ-1:0] rr_exp [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                     4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};

    initial begin
        rst_n = 1'b0; req = '0; dly = '0; cancel = 1'b0;
        tick(); tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_remain", remain, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        rst_n = 1'b1;

        // Single request with remain countdown.
        dly[0 +: N] = 8'd3;
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_gnt", gnt, 4'b0001);
            chk("t1_remain", remain, 3 - i);
            chk("t1_busy", busy, 1);
            if (i == 0) req = '0;
        end
        tick();
        chk("t1_done", done, 4'b0001);
        chk("t1_gnt_low", gnt, 0);
        tick();
        chk("t1_done_clr", done, 0);

        // Fairness from a fresh pointer.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dly = {NREQ{8'd1}};
        req = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk("rr_gnt", gnt, rr_exp[i]);
        end
        req = '0;
        wait_idle();

        svc(1, 0, "zero");
        svc(3, 255, "max");

        // Cancel on the fourth grant cycle.
        dly = {NREQ{8'd1}};
        dly[2*N +: N] = 8'd10;
        req = 4'b0100;
        tick();
        chk("cx_gnt", gnt, 4'b0100);
        req = '0;
        tick(); tick(); tick();
        chk("cx_remain4", remain, 7);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cx_gnt_low", gnt, 0);
        chk("cx_aborted", aborted, 4'b0100);
        chk("cx_done", done, 0);
        chk("cx_remain", remain, 0);
        req = 4'b1111;
        tick();
        chk("cx_aborted_clr", aborted, 0);
        chk("cx_next", gnt, 4'b1000);
        req = '0;
        wait_idle();
        cancel = 1'b1;
        tick(); tick();
        cancel = 1'b0;
        chk("idle_cancel", aborted, 0);

        // Reset in the middle of a service.
        dly[1*N +: N] = 8'd8;
        req = 4'b0010;
        tick();
        chk("rm_gnt", gnt, 4'b0010);
        req = '0;
        tick(); tick(); tick();
        chk("rm_remain", remain, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_gnt0", gnt, 0);
        chk("rm_busy0", busy, 0);
        chk("rm_remain0", remain, 0);
        chk("rm_done0", done, 0);
        chk("rm_aborted0", aborted, 0);
        tick();
        rst_n = 1'b1;
        dly = {NREQ{8'd1}};
        req = 4'b1111;
        tick();
        chk("rm_first", gnt, 4'b0001);
        req = '0;
        wait_idle();

        // Requester drops req right after its grant.
        svc(0, 4, "drop");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
